// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions (FSM states, default bit timing)
//                used by the transmitter and the matching receiver stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Default bit period: 50 MHz system clock at 1 Mbaud.
    localparam int c_DEFAULT_CLK_PER_BIT = 50;

    // Number of data bits per 8N1 frame.
    localparam int c_DATA_BITS = 8;

    // Frame sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_byte_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_byte_tx_if
//  Description : Byte request / flow-control / serial-line bundle between the
//                message source (master) and the UART transmitter (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_byte_tx_if;

    logic [7:0] tx_data;      // byte to send, sampled in the accept cycle
    logic       new_tx_data;  // one-cycle request strobe
    logic       block;        // hold off new frames
    logic       tx_busy;      // request will not be accepted this cycle
    logic       tx;           // serial line, idle high

    modport master (
        output tx_data,
        output new_tx_data,
        output block,
        input  tx_busy,
        input  tx
    );

    modport slave (
        input  tx_data,
        input  new_tx_data,
        input  block,
        output tx_busy,
        output tx
    );

endinterface : uart_byte_tx_if
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_bit_timer
//  Description : Free-running bit-period counter. Counts 0..CLK_PER_BIT-1 and
//                wraps; bit_done_o is high in the last cycle of each period.
//                clear_i holds the count at zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
    parameter int CLK_PER_BIT = 50
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear_i,
    output logic      bit_done_o
);

    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(CLK_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: hold at zero while cleared, otherwise count and wrap.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear_i || (cnt_q == c_LAST)) begin
            cnt_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_done_o = (cnt_q == c_LAST);

endmodule : uart_bit_timer
`default_nettype wire

// File: rtl/uart_byte_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_byte_tx
//  Description : 8N1 UART byte transmitter. Accepts one byte per request,
//                sends start bit, 8 data bits LSB first and STOP_BITS stop
//                bit periods. tx and tx_busy are registered outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = c_DEFAULT_CLK_PER_BIT,
    parameter int STOP_BITS   = 1
) (
    input  wire logic      clk,
    input  wire logic      rst,
    uart_byte_tx_if.slave  bus
);

    localparam logic [2:0] c_LAST_DATA = 3'(c_DATA_BITS - 1);
    localparam logic [2:0] c_LAST_STOP = 3'(STOP_BITS - 1);

    uart_state_e state_q, state_d;
    logic [2:0]  bit_idx_q, bit_idx_d;   // data bit index, reused as stop-bit index
    logic [7:0]  shift_q, shift_d;       // latched byte, shifted right per data bit
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        w_bit_done;
    logic        w_accept;

    // Timer is held at zero while idle so a frame starts on a fresh period.
    uart_bit_timer #(
        .CLK_PER_BIT (CLK_PER_BIT)
    ) u_bit_timer (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (state_q == IDLE),
        .bit_done_o (w_bit_done)
    );

    assign w_accept = (state_q == IDLE) && !bus.block && bus.new_tx_data;

    // Next-state, shift register and registered-output values.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    state_d   = START;
                    shift_d   = bus.tx_data;
                    bit_idx_d = '0;
                end
            end
            START: begin
                if (w_bit_done) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (w_bit_done) begin
                    if (bit_idx_q == c_LAST_DATA) begin
                        state_d   = STOP;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end
            end
            STOP: begin
                if (w_bit_done) begin
                    if (bit_idx_q == c_LAST_STOP) begin
                        state_d   = IDLE;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Line level follows the state being entered so tx stays registered.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase

        busy_d = bus.block | (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;

endmodule : uart_byte_tx
`default_nettype wire

// File: tb/tb_uart_byte_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_byte_tx
//  Description : Self-checking bench for uart_byte_tx. A waveform-queue model
//                predicts tx and tx_busy every cycle from directed and random
//                requests.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_byte_tx;

    localparam int CLK_PER_BIT = 4;
    localparam int STOP_BITS   = 1;
    localparam int FRAME_CYC   = (9 + STOP_BITS) * CLK_PER_BIT;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_byte_tx_if ifc ();

    uart_byte_tx #(
        .CLK_PER_BIT (CLK_PER_BIT),
        .STOP_BITS   (STOP_BITS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            if (n_bad <= 40) begin
                $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue of future line levels, one per cycle.
    // A request is accepted only when the previous cycle drew nothing
    // from the queue (transmitter idle).
    // ------------------------------------------------------------------
    bit   m_q[$];
    bit   m_idle  = 1'b1;
    bit   m_valid = 1'b0;
    logic exp_tx   = 1'b1;
    logic exp_busy = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_idle   = 1'b1;
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
            m_valid  = 1'b1;
        end else begin
            if (m_idle && !ifc.block && ifc.new_tx_data) begin
                logic [7:0] b;
                b = ifc.tx_data;
                for (int k = 0; k < 9 + STOP_BITS; k++) begin
                    bit lvl;
                    if (k == 0)      lvl = 1'b0;
                    else if (k <= 8) lvl = b[k-1];
                    else             lvl = 1'b1;
                    for (int c = 0; c < CLK_PER_BIT; c++) m_q.push_back(lvl);
                end
            end
            if (m_q.size() > 0) begin
                exp_tx = m_q.pop_front();
                m_idle = 1'b0;
            end else begin
                exp_tx = 1'b1;
                m_idle = 1'b1;
            end
            exp_busy = ifc.block | !m_idle;
        end
    end

    // Per-cycle comparison on the falling edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check_eq("tx", {31'd0, ifc.tx}, {31'd0, exp_tx});
            check_eq("tx_busy", {31'd0, ifc.tx_busy}, {31'd0, exp_busy});
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] b);
        ifc.tx_data     = b;
        ifc.new_tx_data = 1'b1;
        tick();
        ifc.new_tx_data = 1'b0;
        ifc.tx_data     = 8'($urandom);
    endtask

    // Returns in the first cycle tx_busy is low.
    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (ifc.tx_busy && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check_eq(tag, 32'd1, 32'd0);
    endtask

    task automatic busy_len(input string tag);
        int n;
        n = 0;
        while (ifc.tx_busy && n < 200) begin
            tick();
            n++;
        end
        check_eq(tag, n, FRAME_CYC);
    endtask

    initial begin
        ifc.tx_data     = 8'h00;
        ifc.new_tx_data = 1'b0;
        ifc.block       = 1'b0;
        rst             = 1'b1;

        // 1: reset held for 4 cycles, then quiet line
        repeat (4) tick();
        rst = 1'b0;
        repeat (5) tick();

        // 2: single frame, busy length
        pulse(8'hA5);
        busy_len("busy_len_a5");
        repeat (3) tick();

        // 3: back-to-back frames with zero idle gap
        pulse(8'h55);
        wait_idle("wait_55");
        pulse(8'h0F);
        busy_len("busy_len_0f");
        repeat (3) tick();

        // 4: request mid-frame is ignored
        pulse(8'h81);
        repeat (9) tick();
        pulse(8'hFF);
        wait_idle("wait_81");
        repeat (FRAME_CYC + 4) tick();

        // 5: block holds off frames; raising it mid-frame lets the frame finish
        ifc.block = 1'b1;
        tick();
        pulse(8'h3C);
        repeat (3) tick();
        check_eq("blk_busy", {31'd0, ifc.tx_busy}, 32'd1);
        check_eq("blk_line", {31'd0, ifc.tx}, 32'd1);
        ifc.block = 1'b0;
        tick();
        pulse(8'h3C);
        repeat (10) tick();
        ifc.block = 1'b1;
        repeat (FRAME_CYC) tick();
        check_eq("blk_park_busy", {31'd0, ifc.tx_busy}, 32'd1);
        check_eq("blk_park_tx", {31'd0, ifc.tx}, 32'd1);
        ifc.block = 1'b0;
        repeat (3) tick();

        // 6: reset during data bit 3, then a clean frame
        pulse(8'hA5);
        repeat (4 * CLK_PER_BIT + 1) tick();
        rst = 1'b1;
        tick();
        check_eq("rst_mid_tx", {31'd0, ifc.tx}, 32'd1);
        check_eq("rst_mid_busy", {31'd0, ifc.tx_busy}, 32'd0);
        rst = 1'b0;
        tick();
        pulse(8'h01);
        busy_len("busy_len_01");
        repeat (3) tick();

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            rst             = ($urandom_range(0, 399) == 0);
            ifc.new_tx_data = ($urandom_range(0, 5) == 0);
            ifc.tx_data     = 8'($urandom);
            if ($urandom_range(0, 59) == 0) ifc.block = ~ifc.block;
            tick();
        end
        rst             = 1'b0;
        ifc.new_tx_data = 1'b0;
        ifc.block       = 1'b0;
        repeat (FRAME_CYC + 4) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_uart_byte_tx
`default_nettype wire
